derandomizer: RTL
=================

# derandomizer

Receive-side counterpart of the CCSDS transmit randomizer. The block accepts a stream of 2-bit channel symbols and hunts for the 32-bit attached sync marker (ASM). It restarts the Gold pseudo-random sequence at each frame start, XORs the sequence onto the frame payload, and emits descrambled symbols with frame delimiters. It sits between the demodulator symbol output and the frame decoder, and keeps frame lock with a flywheel.

## Interface
- FRAME_SYMS, 4080: payload symbols (2 bits each) per frame, excluding the ASM; must be ≥ 2.
- ASM, 32'h1ACFFC1D: sync marker; bit 31 is first in time.
- ASM_TOL, 0: maximum bit mismatches (Hamming distance) still accepted as a marker match.
- MISS_LIMIT, 3: consecutive failed marker checks that drop lock.
- i_clk  in  1  clock; all logic on posedge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_valid  in  1  i_sym is valid this cycle; when low, all state holds.
- i_sym  in  2  channel symbol; i_sym[1] is earlier in time than i_sym[0].
- o_valid  out  1  o_data valid (one pulse per accepted payload symbol).
- o_data  out  2  descrambled payload symbol, same bit order as i_sym.
- o_sof  out  1  qualifies o_valid: first payload symbol of a frame.
- o_eof  out  1  qualifies o_valid: last payload symbol of a frame.
- o_locked  out  1  frame lock indicator.
- o_sync_err  out  1  one-cycle pulse when lock is dropped.

## Operation
Sequence generator:
- State: 18-bit x (init 18'h00001) and 18-bit y (init 18'h3FFFF).
- Symbol value: seq[0] = x[0]^y[0].
- seq[1] = (x[4]^x[6]^x[15]) ^ (y[5]^y[6]^y[8]^y[9]^y[10]^y[11]^y[12]^y[13]^y[14]^y[15]).
- Advance: x <= {x[7]^x[0], x[17:1]}; y <= {y[10]^y[7]^y[5]^y[0], y[17:1]}.
- The first payload symbol of every frame uses the init state. The generator advances once per payload symbol, so the sequence starts 00, 01, 01, …

Marker window:
- 32-bit shift register sr, updated on each valid symbol: sr <= {sr[29:0], i_sym}.
- A match compares {sr[29:0], i_sym} against ASM, so a match is available in the same cycle as the last marker symbol.

States:
- HUNT:
  - Shifts every valid symbol into the window.
  - On a match (≤ ASM_TOL mismatches): go to PAYLOAD, load the sequence init, set cnt=0, set miss=0, set o_locked=1.
  - Detection is at symbol (2-bit) granularity only.
- PAYLOAD:
  - Per valid symbol: o_data <= i_sym ^ seq, o_valid <= 1, o_sof <= (cnt==0), o_eof <= (cnt==FRAME_SYMS-1). Then advance the sequence and increment cnt.
  - After symbol FRAME_SYMS-1: go to CHECK with cnt=0.
- CHECK:
  - Shifts 16 valid symbols into the window; produces no output.
  - On the 16th symbol, with a match: set miss=0, go to PAYLOAD, reload the sequence init.
  - On the 16th symbol, with no match: miss+1.
    - If miss+1 == MISS_LIMIT: go to HUNT, set o_locked=0, pulse o_sync_err, set miss=0.
    - Otherwise (flywheel): go to PAYLOAD, reload the sequence init, keep o_locked=1.

Counter widths:
- cnt: $clog2(FRAME_SYMS) bits.
- CHECK symbol counter: 4 bits.
- miss: $clog2(MISS_LIMIT+1) bits.

## Timing
- Reset values:
  - o_valid, o_sof, o_eof, o_locked, o_sync_err = 0; o_data = 2'b00.
  - State HUNT; sr = 0; x, y at init; cnt = 0; miss = 0.
- Latency: o_data, o_valid, o_sof and o_eof appear one cycle after the accepting edge (registered).
- o_valid and o_sync_err are single-cycle and deassert on the next edge.
- Gaps in i_valid: no output, no advance of state or sequence; sof/eof positions are unaffected.
- o_locked changes on the same edge as the state transition.
- Reset mid-frame: immediate return to the reset values; the partial frame is discarded and no o_eof is emitted.
- In HUNT, an ASM that overlaps the previous window is still detected (sliding window, no blanking).

## Test plan
- Lock on a clean frame:
  - Stimulus: ASM, then FRAME_SYMS scrambled zero-payload symbols (first three channel symbols 00, 01, 01).
  - Required: o_locked rises on the last ASM symbol's edge; all o_data are 00.
  - Required: o_sof on payload symbol 0 only, o_eof on symbol FRAME_SYMS-1 only.
- Back-to-back frames with ASMs, with i_valid toggled randomly:
  - Required: continuous lock and miss=0.
  - Required: the sequence restarts at each frame, so the first three symbols of every frame descramble correctly.
- Flywheel, MISS_LIMIT=3:
  - Stimulus: corrupt 2 consecutive ASMs.
  - Required: o_locked stays 1, the next frames are still output, and no o_sync_err.
  - Stimulus: corrupt 3 consecutive ASMs.
  - Required: o_sync_err pulses once, o_locked=0, state HUNT, and no o_valid until the next valid ASM.
- Tolerance, ASM_TOL=2:
  - Stimulus: a marker with 2 bit errors, then one with 3 bit errors.
  - Required: the first is accepted; the second is rejected in HUNT.
- Random noise before the ASM:
  - Stimulus: 100 random symbols, then the ASM.
  - Required: lock occurs exactly at the marker end (noise contains no ASM pattern).
- Mid-frame reset:
  - Stimulus: assert i_reset at payload symbol 10.
  - Required: all outputs 0 asynchronously; after release the block re-hunts and locks on the next ASM.

Source files
------------

// File: rtl/derandomizer.sv
// Receive-side CCSDS derandomizer: hunts for the attached sync marker, restarts the
// Gold sequence at each frame and descrambles the payload, holding lock with a flywheel.
module derandomizer #(
    parameter int          FRAME_SYMS = 4080,
    parameter logic [31:0] ASM        = 32'h1ACFFC1D,
    parameter int          ASM_TOL    = 0,
    parameter int          MISS_LIMIT = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_valid,
    input  logic [1:0] i_sym,
    output logic       o_valid,
    output logic [1:0] o_data,
    output logic       o_sof,
    output logic       o_eof,
    output logic       o_locked,
    output logic       o_sync_err
);
    localparam int CNT_W  = $clog2(FRAME_SYMS);
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);
    localparam logic [17:0]       X_INIT    = 18'h00001;
    localparam logic [17:0]       Y_INIT    = 18'h3FFFF;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_SYMS - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);

    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

    function automatic logic asm_match(input logic [31:0] win);
        return $countones(win ^ ASM) <= ASM_TOL;
    endfunction

    function automatic logic [1:0] gold_sym(input logic [17:0] x, input logic [17:0] y);
        logic s1;
        s1 = (x[4] ^ x[6] ^ x[15]) ^
             (y[5] ^ y[6] ^ y[8] ^ y[9] ^ y[10] ^ y[11] ^ y[12] ^ y[13] ^ y[14] ^ y[15]);
        return {s1, x[0] ^ y[0]};
    endfunction

    function automatic logic [17:0] x_step(input logic [17:0] x);
        return {x[7] ^ x[0], x[17:1]};
    endfunction

    function automatic logic [17:0] y_step(input logic [17:0] y);
        return {y[10] ^ y[7] ^ y[5] ^ y[0], y[17:1]};
    endfunction

    state_t              state, state_nx;
    logic [31:0]         sr;
    logic [17:0]         x, y;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [3:0]          chk_cnt, chk_nx;
    logic [MISS_W-1:0]   miss, miss_nx;
    logic                seq_load, seq_adv;
    logic                locked_nx, err_nx, out_v, out_sof, out_eof;
    logic [31:0]         win;
    logic                match;

    // The window includes the symbol arriving now, so a marker is seen on its last symbol.
    assign win   = {sr[29:0], i_sym};
    assign match = asm_match(win);

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        chk_nx    = chk_cnt;
        miss_nx   = miss;
        seq_load  = 1'b0;
        seq_adv   = 1'b0;
        locked_nx = o_locked;
        err_nx    = 1'b0;
        out_v     = 1'b0;
        out_sof   = 1'b0;
        out_eof   = 1'b0;
        if (i_valid) begin
            case (state)
                HUNT: begin
                    if (match) begin
                        state_nx  = PAYLOAD;
                        seq_load  = 1'b1;
                        cnt_nx    = '0;
                        miss_nx   = '0;
                        locked_nx = 1'b1;
                    end
                end
                PAYLOAD: begin
                    out_v   = 1'b1;
                    out_sof = (cnt == '0);
                    out_eof = (cnt == CNT_LAST);
                    seq_adv = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nx = CHECK;
                        cnt_nx   = '0;
                        chk_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (chk_cnt == 4'd15) begin
                        chk_nx = '0;
                        if (match) begin
                            miss_nx  = '0;
                            state_nx = PAYLOAD;
                            seq_load = 1'b1;
                        end else if (miss == MISS_LAST) begin
                            // Too many consecutive misses: give up the flywheel and re-hunt.
                            state_nx  = HUNT;
                            locked_nx = 1'b0;
                            err_nx    = 1'b1;
                            miss_nx   = '0;
                        end else begin
                            miss_nx  = miss + 1'b1;
                            state_nx = PAYLOAD;
                            seq_load = 1'b1;
                        end
                    end else begin
                        chk_nx = chk_cnt + 1'b1;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= HUNT;
            sr         <= '0;
            x          <= X_INIT;
            y          <= Y_INIT;
            cnt        <= '0;
            chk_cnt    <= '0;
            miss       <= '0;
            o_valid    <= 1'b0;
            o_data     <= 2'b00;
            o_sof      <= 1'b0;
            o_eof      <= 1'b0;
            o_locked   <= 1'b0;
            o_sync_err <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            chk_cnt    <= chk_nx;
            miss       <= miss_nx;
            o_valid    <= out_v;
            o_sof      <= out_sof;
            o_eof      <= out_eof;
            o_locked   <= locked_nx;
            o_sync_err <= err_nx;
            if (i_valid) begin
                sr <= win;
            end
            if (out_v) begin
                o_data <= i_sym ^ gold_sym(x, y);
            end
            if (seq_load) begin
                x <= X_INIT;
                y <= Y_INIT;
            end else if (seq_adv) begin
                x <= x_step(x);
                y <= y_step(y);
            end
        end
    end
endmodule
